// File: rtl/accum_frame_ctrl_if.sv
// rtl/accum_frame_ctrl_if.sv - sample stream, result stream and accumulator hookup for accum_frame_ctrl
interface accum_frame_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        acc_nrst;
  logic        acc_ce;
  logic [31:0] acc_val;
  logic [31:0] acc_out;

  modport master (
    input  s_valid, s_data, m_ready, acc_out,
    output s_ready, m_valid, m_data, acc_nrst, acc_ce, acc_val
  );

  modport slave (
    output s_valid, s_data, m_ready, acc_out,
    input  s_ready, m_valid, m_data, acc_nrst, acc_ce, acc_val
  );
endinterface

// File: rtl/accum_frame_ctrl.sv
// rtl/accum_frame_ctrl.sv - frame sequencer owning the FFT accumulator clear/enable and result capture
// Optional per-component prescale of the accumulator input: ACCUM_FRAME_CTRL_PRESCALE_EN.
module accum_frame_ctrl #(
  parameter int LEN_W = 10,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  accum_frame_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, ARM, ACCUM, DRAIN, OUT} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             s_ready_q;
  logic             acc_nrst_q;
  logic             m_valid_q;
  logic [31:0]      m_data_q;
  logic             busy_q;
  logic             fire;
  logic [31:0]      scaled;

  if (SHIFT < 0 || SHIFT > 15) begin : g_bad_shift
    $error("accum_frame_ctrl: SHIFT must be within 0..15");
  end

`ifdef ACCUM_FRAME_CTRL_PRESCALE_EN
  logic signed [15:0] s_re;
  logic signed [15:0] s_im;
  assign s_re   = $signed(bus.s_data[31:16]) >>> SHIFT;
  assign s_im   = $signed(bus.s_data[15:0]) >>> SHIFT;
  assign scaled = {s_re, s_im};
`else
  assign scaled = bus.s_data;
`endif

  assign fire    = s_ready_q & bus.s_valid;
  assign cnt_nxt = cnt + LEN_W'(1);

  // s_ready_q doubles as the "in ACCUM" flag for the accumulator-facing outputs.
  assign bus.s_ready  = s_ready_q;
  assign bus.acc_ce   = fire;
  assign bus.acc_val  = s_ready_q ? scaled : 32'd0;
  assign bus.acc_nrst = acc_nrst_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign busy         = busy_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      s_ready_q  <= 1'b0;
      acc_nrst_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 32'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= CLEAR;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          len_q      <= cfg_len;
          cnt        <= '0;
          acc_nrst_q <= 1'b1;
          state      <= ARM;
        end
        // ARM lets the accumulator's registered clear land before the first ce.
        ARM: begin
          s_ready_q <= 1'b1;
          state     <= ACCUM;
        end
        ACCUM: begin
          if (fire) begin
            cnt <= cnt_nxt;
            // len_q of zero is reached only after the counter wraps: full range.
            if (cnt_nxt == len_q) begin
              s_ready_q <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          m_data_q  <= bus.acc_out;
          m_valid_q <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_q  <= 1'b0;
            acc_nrst_q <= 1'b0;
            if (enable) begin
              state <= CLEAR;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          s_ready_q  <= 1'b0;
          acc_nrst_q <= 1'b0;
          m_valid_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// tb/tb_accum_frame_ctrl.sv - randomized scoreboard bench for accum_frame_ctrl with a behavioural accumulator
module tb_accum_frame_ctrl;
  localparam int LEN_W = 4;
  localparam int SHIFT = 2;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             enable = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             busy;

  always #5 clk = ~clk;

  accum_frame_ctrl_if bus();

  accum_frame_ctrl #(.LEN_W(LEN_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .cfg_len(cfg_len), .busy(busy), .bus(bus)
  );

  // Accumulation unit: registered sum, one-cycle registered clear, per-component wrap.
  logic [31:0] acc_reg;
  always @(posedge clk) begin
    if (!bus.acc_nrst) acc_reg <= 32'd0;
    else if (bus.acc_ce) acc_reg <= {acc_reg[31:16] + bus.acc_val[31:16], acc_reg[15:0] + bus.acc_val[15:0]};
  end
  assign bus.acc_out = acc_reg;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] src_q[$];
  logic [31:0] exp_sum_q[$];
  int          exp_len_q[$];
  int          plan_q[$];
  int          valid_pct = 100;
  int          ready_pct = 100;
  int          frame_hs = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scale(input int v);
`ifdef ACCUM_FRAME_CTRL_PRESCALE_EN
    int d;
    d = 1 << SHIFT;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] model_val(input logic [31:0] s);
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [31:0] rr;
    logic [31:0] ii;
    re = s[31:16];
    im = s[15:0];
    rr = scale(int'(re));
    ii = scale(int'(im));
    return {rr[15:0], ii[15:0]};
  endfunction

  // mode 0: constant v, mode 1: real 1..n with imag -1, mode 2: random
  task automatic push_frame(input int len, input int mode, input logic [31:0] v);
    int n;
    int sr;
    int si;
    logic [31:0] smp;
    logic [31:0] m;
    logic [31:0] rs;
    logic [31:0] is;
    n  = (len == 0) ? (1 << LEN_W) : len;
    sr = 0;
    si = 0;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       smp = v;
        1:       smp = {16'(k + 1), 16'hFFFF};
        default: smp = $urandom;
      endcase
      src_q.push_back(smp);
      m  = model_val(smp);
      sr += int'($signed(m[31:16]));
      si += int'($signed(m[15:0]));
    end
    rs = sr;
    is = si;
    exp_sum_q.push_back({rs[15:0], is[15:0]});
    exp_len_q.push_back(n);
    plan_q.push_back(len);
  endtask

  task automatic wait_sready(input logic level, input string name);
    int n;
    n = 0;
    while (bus.s_ready !== level && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(bus.s_ready === level, name, {31'd0, bus.s_ready}, {31'd0, level});
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(bus.m_valid === 1'b1, "wait_m_valid", {31'd0, bus.m_valid}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check(bus.acc_nrst === 1'b0, {tag, "_acc_nrst"}, {31'd0, bus.acc_nrst}, 32'd0);
    check(bus.acc_ce === 1'b0, {tag, "_acc_ce"}, {31'd0, bus.acc_ce}, 32'd0);
    check(bus.acc_val === 32'd0, {tag, "_acc_val"}, bus.acc_val, 32'd0);
    check(bus.s_ready === 1'b0, {tag, "_s_ready"}, {31'd0, bus.s_ready}, 32'd0);
    check(bus.m_valid === 1'b0, {tag, "_m_valid"}, {31'd0, bus.m_valid}, 32'd0);
    check(bus.m_data === 32'd0, {tag, "_m_data"}, bus.m_data, 32'd0);
    check(busy === 1'b0, {tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic flush();
    src_q.delete();
    exp_sum_q.delete();
    exp_len_q.delete();
    plan_q.delete();
    frame_hs = 0;
  endtask

  // Runs every planned frame; enable drops and cfg_len scrambles mid-way through the last one.
  task automatic run_plan(input int hold);
    int n;
    int tmp;
    int w;
    n   = plan_q.size();
    tmp = plan_q.pop_front();
    cfg_len = tmp[LEN_W-1:0];
    enable  = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_sready(1'b1, "frame_start");
      if (i == n - 1) begin
        enable  = 1'b0;
        cfg_len = LEN_W'($urandom);
      end else begin
        tmp = plan_q.pop_front();
        cfg_len = tmp[LEN_W-1:0];
      end
      wait_sready(1'b0, "frame_end");
    end
    if (hold > 0) begin
      wait_mvalid();
      repeat (hold) @(negedge clk);
      ready_pct = 100;
    end
    w = 0;
    while (exp_sum_q.size() > 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check(exp_sum_q.size() == 0, "results_pending", exp_sum_q.size(), 32'd0);
    check(src_q.size() == 0, "samples_left", src_q.size(), 32'd0);
    repeat (4) @(negedge clk);
    check(busy === 1'b0, "idle_busy", {31'd0, busy}, 32'd0);
    check(bus.acc_nrst === 1'b0, "idle_acc_nrst", {31'd0, bus.acc_nrst}, 32'd0);
  endtask

  // Source and sink driver: changes inputs 1 time unit after each rising edge.
  initial begin
    bit hs;
    bus.s_valid = 1'b0;
    bus.s_data  = 32'd0;
    bus.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready && nrst;
      @(posedge clk);
      #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      bus.s_valid = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
      bus.s_data  = (src_q.size() > 0) ? src_q[0] : $urandom;
      bus.m_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor and scoreboard.
  initial begin
    int          cyc;
    int          last_hs;
    logic        pv;
    logic        pr;
    logic [31:0] pd;
    logic [31:0] es;
    int          el;
    cyc = 0;
    last_hs = 0;
    pv = 1'b0;
    pr = 1'b0;
    pd = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nrst) begin
        pv = 1'b0;
        pr = 1'b0;
        continue;
      end
      check(bus.acc_ce === (bus.s_valid && bus.s_ready), "acc_ce", {31'd0, bus.acc_ce}, {31'd0, bus.s_valid && bus.s_ready});
      if (bus.acc_ce) check(bus.acc_val === model_val(bus.s_data), "acc_val", bus.acc_val, model_val(bus.s_data));
      if (!bus.s_ready) check(bus.acc_val === 32'd0, "acc_val_quiet", bus.acc_val, 32'd0);
      if (bus.s_valid && bus.s_ready) begin
        frame_hs++;
        last_hs = cyc;
      end
      if (pv && !pr) begin
        check(bus.m_valid === 1'b1, "out_hold_valid", {31'd0, bus.m_valid}, 32'd1);
        check(bus.m_data === pd, "out_hold_data", bus.m_data, pd);
      end
      if (bus.m_valid && !pv) check(cyc - last_hs == 2, "result_latency", cyc - last_hs, 32'd2);
      if (bus.m_valid) check(!bus.s_ready && !bus.acc_ce, "out_quiet", {30'd0, bus.s_ready, bus.acc_ce}, 32'd0);
      if (bus.m_valid && bus.m_ready) begin
        check(exp_sum_q.size() > 0, "unexpected_result", bus.m_data, 32'd0);
        if (exp_sum_q.size() > 0) begin
          es = exp_sum_q.pop_front();
          el = exp_len_q.pop_front();
          check(bus.m_data === es, "frame_sum", bus.m_data, es);
          check(frame_hs == el, "frame_len", frame_hs, el);
        end
        frame_hs = 0;
      end
      pv = bus.m_valid;
      pr = bus.m_ready;
      pd = bus.m_data;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame
    push_frame(4, 1, 32'd0);
    run_plan(0);

    // back-to-back frames, bubbly source
    valid_pct = 50;
    push_frame(3, 0, 32'h0001_0001);
    push_frame(3, 0, 32'h0002_0000);
    run_plan(0);

    // output backpressure
    valid_pct = 100;
    ready_pct = 0;
    push_frame(5, 2, 32'd0);
    run_plan(10);

    // enable drop with length change, then 2-sample frames
    push_frame(4, 2, 32'd0);
    run_plan(0);
    push_frame(2, 2, 32'd0);
    push_frame(2, 0, 32'hFFF8_0007);
    run_plan(0);

    // length 0 means full counter range
    push_frame(0, 0, 32'h0001_0000);
    run_plan(0);

    // random frames
    valid_pct = 60;
    ready_pct = 70;
    for (int i = 0; i < 6; i++) push_frame($urandom_range(0, 15), 2, 32'd0);
    push_frame(3, 0, 32'hFFF8_0007);
    run_plan(0);

    // async reset in ACCUM
    valid_pct = 30;
    ready_pct = 100;
    push_frame(8, 2, 32'd0);
    cfg_len = 4'd8;
    plan_q.delete();
    enable = 1'b1;
    wait_sready(1'b1, "abort_accum_start");
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    enable = 1'b0;
    #1 check_reset_vals("abort_accum");
    flush();
    @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    check(busy === 1'b0, "abort_accum_idle", {31'd0, busy}, 32'd0);

    // async reset in OUT: pending result must be discarded
    valid_pct = 100;
    ready_pct = 0;
    push_frame(2, 2, 32'd0);
    cfg_len = 4'd2;
    plan_q.delete();
    enable = 1'b1;
    wait_mvalid();
    enable = 1'b0;
    #2 nrst = 1'b0;
    #1 check_reset_vals("abort_out");
    flush();
    @(negedge clk);
    nrst = 1'b1;
    ready_pct = 100;
    repeat (20) @(negedge clk);
    check(bus.m_valid === 1'b0, "abort_out_no_result", {31'd0, bus.m_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accum_frame_ctrl.md
# accum_frame_ctrl

Frame sequencer for the FFT accumulation unit. Accepts a valid/ready stream of packed complex samples, clears the accumulator and then enables it for exactly `cfg_len` samples per frame. It captures the frame sum and presents it on a valid/ready output port. Frames run back-to-back while `enable` is high. The block sits between the sample source and the accumulation unit and owns the accumulator's `ce` and clear.

## Interface
- `LEN_W`, 10: width of the frame-length configuration and the beat counter.
- `SHIFT`, 2: arithmetic right-shift applied per component when prescale is compiled in.
- `clk` in 1: single clock; all logic on the rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `enable` in 1: run frames continuously while high.
- `cfg_len` in LEN_W: samples per frame; latched in CLEAR; 0 means 2^LEN_W.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: input ready; high only in ACCUM.
- `s_data` in 32: sample; [31:16] real, [15:0] imag, both two's complement.
- `acc_nrst` out 1: accumulator clear, active-low.
- `acc_ce` out 1: accumulator enable.
- `acc_val` out 32: accumulator input.
- `acc_out` in 32: accumulator sum, packed real/imag, combinational from its register.
- `m_valid` out 1: frame result valid.
- `m_ready` in 1: result accepted.
- `m_data` out 32: registered frame sum.
- `busy` out 1: state is not IDLE.

## Operation
- States are IDLE, CLEAR, ARM, ACCUM, DRAIN and OUT.
- IDLE: `acc_nrst`=0. Goes to CLEAR when `enable`=1.
- CLEAR (1 cycle): `acc_nrst`=0. Latches `cfg_len` into `len_q`. Zeroes the beat counter. Goes to ARM.
- ARM (1 cycle): `acc_nrst`=1, `acc_ce`=0, `s_ready`=0. This cycle covers the accumulator's one-cycle registered clear, so the first `ce` is not lost. Goes to ACCUM.
- ACCUM: `s_ready`=1 and `acc_ce`=`s_valid`.
  - `acc_val` is `s_data` combinationally, or prescaled.
  - The counter increments on each handshake.
  - The handshake that brings the counter to `len_q` (LEN_W-bit wrap; 0 means full range) moves the FSM to DRAIN.
- DRAIN (1 cycle): `acc_ce`=0. On the exiting edge, `m_data` <= `acc_out`. Goes to OUT.
- OUT: `m_valid`=1 and `m_data` is stable.
  - On `m_ready`, go to CLEAR if `enable`=1, else IDLE.
  - The accumulator is not touched in OUT.
- `acc_ce` is 0 in every state other than ACCUM.
- `acc_val` is 0 outside ACCUM.
- `enable` is sampled only in IDLE and at the OUT handshake. Deasserting it mid-frame completes the frame and delivers the result.
- `cfg_len` changes take effect at the next CLEAR only.
- `s_valid` gaps in ACCUM stall the count. There is no timeout.

## Timing
- Reset values:
  - state IDLE
  - `acc_nrst`=0
  - `acc_ce`=0
  - `acc_val`=0
  - `s_ready`=0
  - `m_valid`=0
  - `m_data`=0
  - `busy`=0
- Asserting `nrst` mid-frame aborts immediately. A pending OUT result is discarded, not delivered.
- Start latency: from `enable` rising in IDLE, the first `s_ready`=1 occurs 3 cycles later (IDLE→CLEAR→ARM→ACCUM).
- Result latency: if the last sample handshakes at edge E, `m_valid` rises after edge E+1 and `m_data` equals the sum including that sample.
- Frame overhead with an always-ready sink: 2 cycles (OUT handshake→CLEAR→ARM) plus DRAIN plus at least 1 OUT cycle. With `len`=N and no stalls, the frame period is N+4 cycles.
- `m_ready` high while in DRAIN has no effect. Only OUT completes the handshake.

## Configuration
- Macro: `ACCUM_FRAME_CTRL_PRESCALE_EN`.
- Defined: `acc_val` = {`s_data[31:16]`>>>SHIFT, `s_data[15:0]`>>>SHIFT}, each result 16 bits and sign-preserving (floor rounding). This lets long frames fit the 16-bit result slices.
- Undefined: `acc_val` = `s_data` unchanged, and `SHIFT` is ignored.

## Test plan
- Basic frame:
  - Stimulus: reset, `cfg_len`=4, `enable`=1, samples real 1,2,3,4 and imag -1 each, `m_ready`=1.
  - Response: `m_data`=0x000A_FFFC. `m_valid` rises 2 cycles after the 4th handshake.
- Back-to-back frames with a bubbly source:
  - Stimulus: `len`=3, `s_valid` toggling, frame A all 0x0001_0001 and frame B all 0x0002_0000.
  - Response: results 0x0003_0003 then 0x0006_0000. Frame A's sum does not leak into B, and no sample is dropped at the ARM boundary.
- Output backpressure:
  - Stimulus: `m_ready`=0 for 10 cycles in OUT.
  - Response: `m_data` is held, `s_ready`=0 and `acc_ce`=0 throughout. Delivery happens on the cycle `m_ready`=1.
- Enable drop and length change:
  - Stimulus: `enable`→0 mid-frame, and `cfg_len` changed from 4 to 2 mid-frame.
  - Response: the frame completes with 4 samples, then IDLE with `busy`=0. After re-enable, frames are 2 samples long.
- Length 0:
  - Stimulus: `cfg_len`=0 with `LEN_W`=4, 0x0001_0000 samples.
  - Response: exactly 16 samples accepted and result 0x0010_0000.
- Async reset and prescale:
  - Stimulus: assert `nrst` in ACCUM and in OUT.
  - Response: all outputs reach reset values without a clock edge, and no result is delivered.
  - With `ACCUM_FRAME_CTRL_PRESCALE_EN` and `SHIFT`=2, sample 0xFFF8_0007 gives `acc_val`=0xFFFE_0001.
